// File: rtl/fifo_rr_pop_arbiter_pkg.sv
// Shared constants, FSM encoding and in-flight entry type for the
// round-robin pop arbiter.
package fifo_rr_pop_arbiter_pkg;

  localparam int DATA_WIDTH = 10;
  localparam int NUM_SRC    = 4;
  localparam int RD_LAT     = 2;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ARB   = 2'd2,
    STALL = 2'd3
  } state_t;

  // One grant travelling through the upstream read latency.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } flight_t;

endpackage

// File: rtl/fifo_rr_pop_arbiter_if.sv
// Bus between the arbiter, the four upstream FIFOs and the downstream FIFO.
//
// Handshake: the arbiter pops upstream source i by pulsing pop[i] for one
// cycle, and only when src_empty[i]=0. The word appears on
// src_data[i*DATA_WIDTH +: DATA_WIDTH] RD_LAT cycles later. Downstream,
// push is a one-cycle strobe that qualifies data_out. The downstream FIFO
// does not backpressure per word: it raises dst_almost_full early enough
// to absorb every word still in flight.
interface fifo_rr_pop_arbiter_if;
  import fifo_rr_pop_arbiter_pkg::*;

  logic [NUM_SRC-1:0]            src_empty;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            pop;
  logic                          dst_almost_full;
  logic                          dst_full;
  logic                          push;
  logic [DATA_WIDTH-1:0]         data_out;

  modport master (
    input  src_empty, src_data, dst_almost_full, dst_full,
    output pop, push, data_out
  );

  modport slave (
    output src_empty, src_data, dst_almost_full, dst_full,
    input  pop, push, data_out
  );
endinterface

// File: rtl/fifo_rr_pop_arbiter_pick.sv
// Combinational round-robin pick: first eligible source after rr_ptr, modulo
// NUM_SRC, returned one-hot and as an index.
module fifo_rr_pop_arbiter_pick
  import fifo_rr_pop_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  // Walk rr_ptr+1 .. rr_ptr+NUM_SRC; IDX_W-bit add wraps because NUM_SRC is 4.
  always_comb begin
    grant       = '0;
    grant_idx   = rr_ptr;
    grant_valid = 1'b0;
    cand        = rr_ptr;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = rr_ptr + IDX_W'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_pop_arbiter.sv
// Round-robin pop arbiter: pops four upstream FIFOs, tracks each grant
// through the upstream read latency and pushes the word downstream.
module fifo_rr_pop_arbiter
  import fifo_rr_pop_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  fifo_rr_pop_arbiter_if.master        bus,
  output logic                         active,
  output logic                         error,
  output state_t                       dbg_state
);

  state_t                    state_q, state_d;
  logic [NUM_SRC-1:0]        pop_q, pop_d;
  logic [IDX_W-1:0]          pop_idx_q, pop_idx_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  flight_t [RD_LAT-1:0]      flight_q, flight_d;
  logic                      push_q, push_d;
  logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
  logic                      active_q, active_d;
  logic                      error_q, error_d;

  logic [NUM_SRC-1:0]        busy;
  logic [NUM_SRC-1:0]        eligible;
  logic [NUM_SRC-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_valid;
  logic                      grant_en;
  logic                      flags;

  assign flags = bus.dst_almost_full | bus.dst_full;

  // Sources popped in the last RD_LAT cycles still show stale non-empty flags.
  always_comb begin
    busy = pop_q;
    for (int j = 0; j < RD_LAT - 1; j++) begin
      if (flight_q[j].valid) busy[flight_q[j].idx] = 1'b1;
    end
    eligible = ~bus.src_empty & ~busy;
  end

  fifo_rr_pop_arbiter_pick u_pick (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Next state, grant, in-flight shift and downstream push.
  always_comb begin
    state_d    = state_q;
    pop_d      = '0;
    pop_idx_d  = pop_idx_q;
    rr_ptr_d   = rr_ptr_q;
    flight_d   = '0;
    push_d     = 1'b0;
    data_out_d = data_out_q;
    error_d    = error_q | (push_q & bus.dst_full);

    case (state_q)
      INIT:  state_d = IDLE;
      IDLE:  if (enable && |eligible) state_d = ARB;
      ARB: begin
        if (flags)                          state_d = STALL;
        else if (!enable || !(|eligible))   state_d = IDLE;
      end
      STALL: begin
        if (!flags) state_d = (enable && |eligible) ? ARB : IDLE;
      end
      default: state_d = INIT;
    endcase

    // The registered pop is visible exactly while the FSM sits in ARB, so a
    // grant is issued on every cycle whose next state is ARB.
    grant_en = (state_d == ARB) && !flags && grant_valid;
    if (grant_en) begin
      pop_d     = grant;
      pop_idx_d = grant_idx;
      rr_ptr_d  = grant_idx;
    end

    flight_d[0].valid = |pop_q;
    flight_d[0].idx   = pop_idx_q;
    for (int j = 1; j < RD_LAT; j++) flight_d[j] = flight_q[j-1];
    if (state_q == INIT) flight_d = '0;

    // The upstream word is on src_data now; register it with push.
    if (flight_q[RD_LAT-1].valid) begin
      push_d     = 1'b1;
      data_out_d = bus.src_data[int'(flight_q[RD_LAT-1].idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    active_d = (state_d == ARB);
  end

  // State and output registers; reset discards any in-flight words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      pop_q      <= '0;
      pop_idx_q  <= '0;
      rr_ptr_q   <= IDX_W'(NUM_SRC - 1);
      flight_q   <= '0;
      push_q     <= 1'b0;
      data_out_q <= '0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      pop_idx_q  <= pop_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      flight_q   <= flight_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      active_q   <= active_d;
      error_q    <= error_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.data_out = data_out_q;
  assign active       = active_q;
  assign error        = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// Directed bench for fifo_rr_pop_arbiter with a push scoreboard.
module tb_fifo_rr_pop_arbiter;
  import fifo_rr_pop_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   enable;
  logic   active;
  logic   error;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rr_pop_arbiter_if bus ();

  fifo_rr_pop_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus.master),
    .active    (active),
    .error     (error),
    .dbg_state (dbg_state)
  );

  logic [DATA_WIDTH-1:0] src_word [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*DATA_WIDTH +: DATA_WIDTH] = src_word[i];
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  int                    exp_cyc_q[$];
  int                    obs_pop_q[$];
  int                    obs_cyc_q[$];
  int                    push_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every pop expects the popped source's word pushed RD_LAT+1 cycles later.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.pop !== '0) begin
        int idx;
        idx = 0;
        check("pop_onehot", 32'($onehot(bus.pop)), 32'd1);
        for (int i = 0; i < NUM_SRC; i++) if (bus.pop[i]) idx = i;
        exp_q.push_back(src_word[idx]);
        exp_cyc_q.push_back(cyc);
        obs_pop_q.push_back(idx);
        obs_cyc_q.push_back(cyc);
      end
      if (bus.push === 1'b1) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_push", 32'd1, 32'd0);
        end else begin
          check("push_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
          check("push_latency", 32'(cyc - exp_cyc_q.pop_front()), 32'(RD_LAT + 1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k;
    k = 0;
    while (obs_pop_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(obs_pop_q.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_obs();
    obs_pop_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int last;
    int outstanding;
    int pb;
    logic [1:0] exp_order [8];

    enable              = 1'b1;
    bus.src_empty       = 4'b1111;
    bus.dst_almost_full = 1'b0;
    bus.dst_full        = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) src_word[i] = DATA_WIDTH'(i + 1);
    #1 reset = 1'b0;

    // Reset values.
    tick();
    tick();
    check("rst_pop", 32'(bus.pop), 32'd0);
    check("rst_push", 32'(bus.push), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(INIT));

    // All empty: settle in IDLE and stay silent.
    reset = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      check("empty_pop", 32'(bus.pop), 32'd0);
      check("empty_push", 32'(bus.push), 32'd0);
      tick();
    end
    check("empty_state", 32'(dbg_state), 32'(IDLE));

    // All sources non-empty: strict round robin starting at source 0.
    clear_obs();
    bus.src_empty = 4'b0000;
    wait_pops(8, "rr_wait");
    bus.src_empty = 4'b1111;
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 8; i++) check("rr_order", 32'(obs_pop_q[i]), 32'(exp_order[i]));
    for (int i = 1; i < 8; i++) check("rr_b2b", 32'(obs_cyc_q[i] - obs_cyc_q[i-1]), 32'd1);
    wait_drain("rr_drain");

    // Single source: popped every RD_LAT+1 cycles.
    src_word[2] = 10'h2AA;
    clear_obs();
    bus.src_empty = 4'b1011;
    wait_pops(5, "single_wait");
    bus.src_empty = 4'b1111;
    for (int i = 0; i < 5; i++) check("single_idx", 32'(obs_pop_q[i]), 32'd2);
    for (int i = 1; i < 5; i++) check("single_gap", 32'(obs_cyc_q[i] - obs_cyc_q[i-1]), 32'(RD_LAT + 1));
    wait_drain("single_drain");

    // almost_full during ARB: pops stop, in-flight words all pushed, STALL.
    for (int i = 0; i < NUM_SRC; i++) src_word[i] = DATA_WIDTH'(10'h100 + i);
    clear_obs();
    bus.src_empty = 4'b0000;
    wait_pops(3, "af_wait");
    last        = obs_pop_q[obs_pop_q.size()-1];
    outstanding = exp_q.size();
    pb          = push_cnt;
    bus.dst_almost_full = 1'b1;
    tick();
    check("af_state", 32'(dbg_state), 32'(STALL));
    check("af_active", 32'(active), 32'd0);
    for (int c = 0; c < 7; c++) begin
      check("af_no_pop", 32'(bus.pop), 32'd0);
      tick();
    end
    check("af_pushes", 32'(push_cnt - pb), 32'(outstanding));
    check("af_inflight_left", 32'(exp_q.size()), 32'd0);
    clear_obs();
    bus.dst_almost_full = 1'b0;
    wait_pops(1, "af_resume_wait");
    check("af_resume_idx", 32'(obs_pop_q[0]), 32'((last + 1) % NUM_SRC));
    bus.src_empty = 4'b1111;
    wait_drain("af_drain");

    // dst_full while words are in flight: sticky error.
    check("err_clear", 32'(error), 32'd0);
    clear_obs();
    bus.src_empty = 4'b0000;
    wait_pops(1, "full_wait");
    bus.dst_full  = 1'b1;
    bus.src_empty = 4'b1111;
    wait_drain("full_drain");
    tick();
    tick();
    check("err_set", 32'(error), 32'd1);
    bus.dst_full = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("err_sticky", 32'(error), 32'd1);

    // Asynchronous reset mid-stream.
    clear_obs();
    bus.src_empty = 4'b0000;
    wait_pops(4, "midrst_wait");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_pop", 32'(bus.pop), 32'd0);
    check("midrst_push", 32'(bus.push), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(INIT));
    exp_q.delete();
    exp_cyc_q.delete();
    tick();
    tick();
    bus.src_empty = 4'b1111;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("midrst_no_push", 32'(bus.push), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
